// File: rtl/arbiter_burst.sv
// Round-robin burst arbiter: a granted port owns the resource until done, request drop or (with ARBITER_BURST_PREEMPT_EN) budget expiry.
// Latency: request in IDLE -> grant next cycle; release -> one GAP cycle -> arbitration -> new grant three cycles after release.
// Backpressure: none; requesters hold request for the whole burst and simply wait while another port owns the resource.
module arbiter_burst #(
    parameter int NUM_PORTS = 6,
    parameter int MAX_BURST = 16,
    localparam int IDX_W = $clog2(NUM_PORTS),
    localparam int CNT_W = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:NUM_PORTS-1] request,
    input  logic                 done,
    output logic [0:NUM_PORTS-1] grant,
    output logic                 active,
    output logic [IDX_W-1:0]     owner,
    output logic [CNT_W-1:0]     burst_cnt,
    output logic                 preempted
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    state_t               state, state_n;
    logic [IDX_W-1:0]     ptr, ptr_n;
    logic [0:NUM_PORTS-1] grant_n;
    logic [IDX_W-1:0]     owner_n;
    logic [CNT_W-1:0]     cnt_n;
    logic                 active_n;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel;
    logic                 release_now;
    logic [IDX_W-1:0]     owner_next_idx;

    // Cyclic search from ptr; the candidate wraps explicitly at NUM_PORTS-1 so a
    // non-power-of-two port count never produces an out-of-range index.
    always_comb begin
        logic [IDX_W-1:0] cand;
        sel_found = 1'b0;
        sel       = ptr;
        cand      = ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!sel_found && request[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
    end

    // Port after the owner, used as the next priority pointer on release.
    always_comb begin
        owner_next_idx = (owner == LAST_IDX) ? '0 : owner + 1'b1;
    end

`ifdef ARBITER_BURST_PREEMPT_EN
    logic others_req;
    logic budget_hit;
    logic preempted_n;
    logic preempted_q;

    // Budget expiry only forces a release when someone else is waiting.
    always_comb begin
        others_req = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (IDX_W'(p) != owner && request[p]) begin
                others_req = 1'b1;
            end
        end
        budget_hit = (burst_cnt == CNT_W'(MAX_BURST - 1)) && others_req;
    end

    assign release_now = done || !request[owner] || budget_hit;
    assign preempted   = preempted_q;
`else
    assign release_now = done || !request[owner];
    assign preempted   = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/BUSY/GAP machine.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        grant_n  = '0;
        owner_n  = owner;
        cnt_n    = burst_cnt;
`ifdef ARBITER_BURST_PREEMPT_EN
        preempted_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_n      = BUSY;
                    grant_n[sel] = 1'b1;
                    owner_n      = sel;
                    cnt_n        = '0;
                end
            end
            BUSY: begin
                grant_n = grant;
                if (burst_cnt != '1) begin
                    cnt_n = burst_cnt + 1'b1;
                end
                if (release_now) begin
                    state_n = GAP;
                    grant_n = '0;
                    ptr_n   = owner_next_idx;
`ifdef ARBITER_BURST_PREEMPT_EN
                    // Only a pure budget release is reported as a preemption.
                    preempted_n = budget_hit && !done && request[owner];
`endif
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        active_n = |grant_n;
    end

    // State and registered outputs; synchronous active-low reset aborts any burst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            active    <= 1'b0;
            owner     <= '0;
            burst_cnt <= '0;
`ifdef ARBITER_BURST_PREEMPT_EN
            preempted_q <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            grant     <= grant_n;
            active    <= active_n;
            owner     <= owner_n;
            burst_cnt <= cnt_n;
`ifdef ARBITER_BURST_PREEMPT_EN
            preempted_q <= preempted_n;
`endif
        end
    end

endmodule

// File: tb/tb_arbiter_burst.sv
// Directed bench for arbiter_burst with 6 ports and a burst budget of 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Preemption expectations follow whether ARBITER_BURST_PREEMPT_EN is defined.
module tb_arbiter_burst;

    localparam int NP = 6;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          done = 1'b0;
    logic [0:NP-1] request = '0;
    logic [0:NP-1] grant;
    logic          active;
    logic [2:0]    owner;
    logic [2:0]    burst_cnt;
    logic          preempted;

    int n_checks = 0;
    int n_errors = 0;

    arbiter_burst #(.NUM_PORTS(NP), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .done      (done),
        .grant     (grant),
        .active    (active),
        .owner     (owner),
        .burst_cnt (burst_cnt),
        .preempted (preempted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:NP-1] gvec(input int p);
        logic [0:NP-1] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called on the first grant cycle of port p; done is pulsed on cycle len.
    // Returns with the bench sitting on the IDLE cycle after the gap.
    task automatic do_burst(input int p, input int len);
        for (int c = 0; c < len; c++) begin
            check("burst_grant", grant, gvec(p));
            check("burst_owner", owner, p);
            check("burst_cnt", burst_cnt, c);
            check("burst_active", active, 1);
            if (c == len - 1) done = 1'b1;
            step();
        end
        done = 1'b0;
        check("gap_grant", grant, 0);
        check("gap_active", active, 0);
        check("gap_preempted", preempted, 0);
        step();
        check("idle_grant", grant, 0);
    endtask

    initial begin
        // Reset held with every port requesting.
        rst = 1'b0;
        request = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_grant", grant, 0);
            check("rst_active", active, 0);
            check("rst_owner", owner, 0);
            check("rst_cnt", burst_cnt, 0);
            check("rst_preempted", preempted, 0);
        end
        rst = 1'b1;
        step();

        // Round robin with all ports requesting: 0..5 then 0 again.
        do_burst(0, 2);
        for (int p = 1; p < NP; p++) begin
            step();
            do_burst(p, 2);
        end
        step();
        do_burst(0, 2);

        // Minimum burst on port 3 moves the pointer to 4.
        request = gvec(3);
        step();
        do_burst(3, 1);

        // Wrap and skip: pointer 4, ports 1 and 5 requesting.
        request = gvec(1) | gvec(5);
        step();
        do_burst(5, 2);
        step();
        do_burst(1, 1);

        // Request drop on port 2 after three grant cycles; port 4 waits.
        request = gvec(2) | gvec(4);
        step();
        for (int c = 0; c < 3; c++) begin
            check("drop_grant", grant, gvec(2));
            check("drop_cnt", burst_cnt, c);
            step();
        end
        // The third edge above sampled request[2]=1; drop it now.
        request = gvec(4);
        step();
        check("drop_release_grant", grant, 0);
        check("drop_preempted", preempted, 0);
        step();
        step();
        check("next_after_drop", grant, gvec(4));

        // done and request drop together: single release, no preemption.
        done = 1'b1;
        request = '0;
        step();
        done = 1'b0;
        check("both_release_grant", grant, 0);
        check("both_preempted", preempted, 0);
        step();
        step();
        check("idle_no_req", grant, 0);
        check("idle_no_req_active", active, 0);

        // Ports 0 and 3 hold requests and never pulse done.
        request = gvec(0) | gvec(3);
        step();
`ifdef ARBITER_BURST_PREEMPT_EN
        for (int c = 0; c < MB; c++) begin
            check("pre0_grant", grant, gvec(0));
            check("pre0_cnt", burst_cnt, c);
            check("pre0_pulse", preempted, 0);
            step();
        end
        check("pre0_release", grant, 0);
        check("pre0_pulse_hi", preempted, 1);
        step();
        check("pre0_pulse_lo", preempted, 0);
        step();
        for (int c = 0; c < MB; c++) begin
            check("pre3_grant", grant, gvec(3));
            check("pre3_cnt", burst_cnt, c);
            step();
        end
        check("pre3_release", grant, 0);
        check("pre3_pulse_hi", preempted, 1);
        step();
        step();
        check("pre_regrant0", grant, gvec(0));
`else
        for (int c = 0; c < 20; c++) begin
            check("hold0_grant", grant, gvec(0));
            check("hold0_cnt", burst_cnt, (c > 7) ? 7 : c);
            check("hold0_pulse", preempted, 0);
            step();
        end
`endif
        done = 1'b1;
        step();
        done = 1'b0;
        check("done_release", grant, 0);
        check("done_no_pulse", preempted, 0);
        step();

        // Reset on the third BUSY cycle: pointer 1 gives port 2 first.
        request = gvec(0) | gvec(2);
        step();
        check("mid_grant", grant, gvec(2));
        step();
        step();
        check("mid_cnt", burst_cnt, 2);
        rst = 1'b0;
        step();
        check("mid_rst_grant", grant, 0);
        check("mid_rst_active", active, 0);
        check("mid_rst_owner", owner, 0);
        check("mid_rst_cnt", burst_cnt, 0);
        check("mid_rst_pulse", preempted, 0);
        rst = 1'b1;
        step();
        check("post_rst_grant", grant, gvec(0));
        check("post_rst_owner", owner, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
